// File: rtl/pipeline_perf_monitor.sv
// Retire/performance monitor beside the WB stage: counts retired instructions, branches and
// per-cycle pipeline events, drives num_inst/output_port/is_halted and a registered counter read port.
module pipeline_perf_monitor #(
  parameter int WORD_SIZE  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int NUM_EVENTS = 4,
  parameter int SATURATE   = 1,
  localparam int NCNT  = NUM_EVENTS + 2,
  localparam int SEL_W = (NCNT > 1) ? $clog2(NCNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  retire_valid,
  input  logic                  retire_is_branch,
  input  logic                  retire_output_active,
  input  logic [WORD_SIZE-1:0]  retire_output_value,
  input  logic                  retire_halt,
  input  logic [NUM_EVENTS-1:0] evt,
  input  logic                  clear,
  input  logic                  freeze,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [WORD_SIZE-1:0]  num_inst,
  output logic [WORD_SIZE-1:0]  output_port,
  output logic                  output_valid,
  output logic                  is_halted,
  output logic [NCNT-1:0]       overflow
);

  localparam logic [1:0] WARMUP = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt [NCNT];
  logic [NCNT-1:0]      inc;
  logic [CNT_WIDTH-1:0] rd_next;
  logic [WORD_SIZE-1:0] out_val;
  logic                 counting;
  logic                 do_clear;

  // WARMUP swallows the reset-release cycle; HALTED is only left through reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= WARMUP;
    end else begin
      case (state)
        WARMUP:  state <= RUN;
        RUN:     if (retire_valid && retire_halt) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= WARMUP;
      endcase
    end
  end

  assign counting = (state == RUN) && !freeze;
  assign do_clear = (state != WARMUP) && clear;

  always_comb begin
    inc = '0;
    if (counting) begin
      inc[0]        = retire_valid;
      inc[1]        = retire_valid & retire_is_branch;
      inc[NCNT-1:2] = evt;
    end
  end

  // clear beats any same-cycle increment, for both the counters and their sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n || do_clear) begin
      for (int k = 0; k < NCNT; k++) begin
        cnt[k] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        if (inc[k]) begin
          if (&cnt[k]) begin
            overflow[k] <= 1'b1;
            cnt[k]      <= (SATURATE != 0) ? cnt[k] : '0;
          end else begin
            cnt[k] <= cnt[k] + CNT_ONE;
          end
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel == SEL_W'(k)) rd_next = cnt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

  // Architectural outputs follow every real retire in RUN regardless of freeze.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_val      <= '0;
      output_valid <= 1'b0;
      is_halted    <= 1'b0;
    end else if (state == RUN && retire_valid) begin
      out_val      <= retire_output_value;
      output_valid <= retire_output_active;
      is_halted    <= retire_halt;
    end
  end

  assign output_port = output_valid ? out_val : {WORD_SIZE{1'bz}};

  generate
    if (SATURATE != 0 && CNT_WIDTH > WORD_SIZE) begin : g_num_sat
      logic hi_set;
      assign hi_set   = |cnt[0][CNT_WIDTH-1:WORD_SIZE];
      assign num_inst = hi_set ? {WORD_SIZE{1'b1}} : cnt[0][WORD_SIZE-1:0];
    end else begin : g_num_plain
      assign num_inst = cnt[0][WORD_SIZE-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor: one wide saturating instance plus 4-bit saturating and wrapping
// instances, all on shared stimulus, compared against a true-count reference model.
module tb_pipeline_perf_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        retire_valid;
  logic        retire_is_branch;
  logic        retire_output_active;
  logic [15:0] retire_output_value;
  logic        retire_halt;
  logic [3:0]  evt;
  logic        clear;
  logic        freeze;
  logic [2:0]  rd_sel;

  logic [31:0] rd_data_m;
  logic [15:0] num_inst_m, output_port_m;
  logic        output_valid_m, is_halted_m;
  logic [5:0]  overflow_m;

  logic [3:0]  rd_data_s, num_inst_s, output_port_s;
  logic        output_valid_s, is_halted_s;
  logic [5:0]  overflow_s;

  logic [3:0]  rd_data_w, num_inst_w, output_port_w;
  logic        output_valid_w, is_halted_w;
  logic [5:0]  overflow_w;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded true counts since last clear/reset; each instance's view derived from them.
  longint      tcnt [6];
  longint      m_rd_t;
  bit          m_warm, m_halted, m_valid;
  logic [15:0] m_out;

  always #5 clk = ~clk;

  pipeline_perf_monitor u_main (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_is_branch(retire_is_branch),
    .retire_output_active(retire_output_active), .retire_output_value(retire_output_value),
    .retire_halt(retire_halt), .evt(evt), .clear(clear), .freeze(freeze), .rd_sel(rd_sel),
    .rd_data(rd_data_m), .num_inst(num_inst_m), .output_port(output_port_m),
    .output_valid(output_valid_m), .is_halted(is_halted_m), .overflow(overflow_m));

  pipeline_perf_monitor #(.WORD_SIZE(4), .CNT_WIDTH(4), .NUM_EVENTS(4), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_is_branch(retire_is_branch),
    .retire_output_active(retire_output_active), .retire_output_value(retire_output_value[3:0]),
    .retire_halt(retire_halt), .evt(evt), .clear(clear), .freeze(freeze), .rd_sel(rd_sel),
    .rd_data(rd_data_s), .num_inst(num_inst_s), .output_port(output_port_s),
    .output_valid(output_valid_s), .is_halted(is_halted_s), .overflow(overflow_s));

  pipeline_perf_monitor #(.WORD_SIZE(4), .CNT_WIDTH(4), .NUM_EVENTS(4), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_is_branch(retire_is_branch),
    .retire_output_active(retire_output_active), .retire_output_value(retire_output_value[3:0]),
    .retire_halt(retire_halt), .evt(evt), .clear(clear), .freeze(freeze), .rd_sel(rd_sel),
    .rd_data(rd_data_w), .num_inst(num_inst_w), .output_port(output_port_w),
    .output_valid(output_valid_w), .is_halted(is_halted_w), .overflow(overflow_w));

  function automatic longint view(longint t, int w, bit sat);
    longint max;
    max = (longint'(1) << w) - 1;
    if (sat) return (t > max) ? max : t;
    return t & max;
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      foreach (tcnt[k]) tcnt[k] = 0;
      m_rd_t   = 0;
      m_warm   = 1'b1;
      m_halted = 1'b0;
      m_valid  = 1'b0;
      m_out    = '0;
    end else begin
      m_rd_t = (rd_sel < 3'd6) ? tcnt[rd_sel] : 0;
      if (m_warm) begin
        m_warm = 1'b0;
      end else begin
        if (clear) begin
          foreach (tcnt[k]) tcnt[k] = 0;
        end else if (!m_halted && !freeze) begin
          if (retire_valid) begin
            tcnt[0] = tcnt[0] + 1;
            if (retire_is_branch) tcnt[1] = tcnt[1] + 1;
          end
          for (int i = 0; i < 4; i++) if (evt[i]) tcnt[2+i] = tcnt[2+i] + 1;
        end
        if (!m_halted && retire_valid) begin
          m_valid  = retire_output_active;
          m_out    = retire_output_value;
          m_halted = retire_halt;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(string tag);
    logic [5:0] ovf_m, ovf_s;
    for (int k = 0; k < 6; k++) begin
      ovf_m[k] = tcnt[k] > 64'hFFFF_FFFF;
      ovf_s[k] = tcnt[k] > 15;
    end
    chk({tag, " main.rd"},    rd_data_m,            32'(view(m_rd_t, 32, 1'b1)));
    chk({tag, " main.ovf"},   32'(overflow_m),      32'(ovf_m));
    chk({tag, " main.num"},   32'(num_inst_m),      32'(view(tcnt[0], 16, 1'b1)));
    chk({tag, " main.valid"}, 32'(output_valid_m),  32'(m_valid));
    chk({tag, " main.halt"},  32'(is_halted_m),     32'(m_halted));
    chk({tag, " sat.rd"},     32'(rd_data_s),       32'(view(m_rd_t, 4, 1'b1)));
    chk({tag, " sat.ovf"},    32'(overflow_s),      32'(ovf_s));
    chk({tag, " sat.num"},    32'(num_inst_s),      32'(view(tcnt[0], 4, 1'b1)));
    chk({tag, " sat.valid"},  32'(output_valid_s),  32'(m_valid));
    chk({tag, " sat.halt"},   32'(is_halted_s),     32'(m_halted));
    chk({tag, " wrap.rd"},    32'(rd_data_w),       32'(view(m_rd_t, 4, 1'b0)));
    chk({tag, " wrap.ovf"},   32'(overflow_w),      32'(ovf_s));
    chk({tag, " wrap.num"},   32'(num_inst_w),      32'(view(tcnt[0], 4, 1'b0)));
    chk({tag, " wrap.valid"}, 32'(output_valid_w),  32'(m_valid));
    chk({tag, " wrap.halt"},  32'(is_halted_w),     32'(m_halted));
    if (m_valid) begin
      chk({tag, " main.port"}, 32'(output_port_m), 32'(m_out));
      chk({tag, " sat.port"},  32'(output_port_s), 32'(m_out[3:0]));
      chk({tag, " wrap.port"}, 32'(output_port_w), 32'(m_out[3:0]));
    end
  endtask

  // One clock edge: model follows the edge, DUTs are sampled 1 time unit later.
  task automatic apply_stimulus(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic idle_inputs();
    retire_valid = 1'b0; retire_is_branch = 1'b0; retire_output_active = 1'b0;
    retire_output_value = '0; retire_halt = 1'b0; evt = '0; clear = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    rd_sel  = '0;
    $display("[TB] reset");
    apply_stimulus("reset0");
    apply_stimulus("reset1");
    chk("reset num_inst", 32'(num_inst_m), 32'd0);

    $display("[TB] warmup discards first retire");
    reset_n = 1'b1;
    retire_valid = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus("warmup");
    chk("warmup num_inst", 32'(num_inst_m), 32'd3);

    $display("[TB] WWD output port");
    retire_output_active = 1'b1; retire_output_value = 16'h00AB;
    apply_stimulus("wwd");
    chk("wwd port", 32'(output_port_m), 32'h00AB);
    chk("wwd valid", 32'(output_valid_m), 32'd1);
    idle_inputs();
    apply_stimulus("wwd hold");
    chk("wwd hold valid", 32'(output_valid_m), 32'd1);
    retire_valid = 1'b1;
    apply_stimulus("non-wwd");
    chk("non-wwd valid", 32'(output_valid_m), 32'd0);

    $display("[TB] 4-bit saturate/wrap");
    idle_inputs();
    clear = 1'b1;
    apply_stimulus("clr");
    clear = 1'b0; evt = 4'b0001;
    for (int i = 0; i < 17; i++) apply_stimulus("evt0");
    evt = '0; rd_sel = 3'd2;
    apply_stimulus("rd evt0");
    chk("sat evt0", 32'(rd_data_s), 32'd15);
    chk("wrap evt0", 32'(rd_data_w), 32'd1);
    chk("sat ovf2", 32'(overflow_s[2]), 32'd1);
    chk("wrap ovf2", 32'(overflow_w[2]), 32'd1);
    clear = 1'b1;
    apply_stimulus("clr2");
    clear = 1'b0;
    apply_stimulus("rd after clr");
    chk("sat cleared", 32'(rd_data_s), 32'd0);
    chk("sat ovf cleared", 32'(overflow_s[2]), 32'd0);

    $display("[TB] clear priority, freeze, out-of-range select");
    retire_valid = 1'b1; clear = 1'b1;
    apply_stimulus("clr+retire");
    idle_inputs(); rd_sel = 3'd0;
    apply_stimulus("rd c0");
    chk("clr prio c0", rd_data_m, 32'd0);
    evt = 4'b0010;
    apply_stimulus("evt1a");
    apply_stimulus("evt1b");
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus("frozen evt1");
    idle_inputs(); rd_sel = 3'd3;
    apply_stimulus("rd c3");
    chk("freeze c3", rd_data_m, 32'd2);
    rd_sel = 3'd6;
    apply_stimulus("rd sel6");
    chk("sel6 reads 0", rd_data_m, 32'd0);

    $display("[TB] randomized phase");
    for (int i = 0; i < 400; i++) begin
      reset_n              = ($urandom_range(0, 49) != 0);
      retire_valid         = $urandom_range(0, 1) != 0;
      retire_is_branch     = $urandom_range(0, 2) == 0;
      retire_output_active = $urandom_range(0, 3) == 0;
      retire_output_value  = 16'($urandom);
      retire_halt          = $urandom_range(0, 63) == 0;
      evt                  = 4'($urandom);
      clear                = $urandom_range(0, 19) == 0;
      freeze               = $urandom_range(0, 7) == 0;
      rd_sel               = 3'($urandom);
      apply_stimulus("rand");
    end

    $display("[TB] halt");
    idle_inputs(); reset_n = 1'b0; rd_sel = '0;
    apply_stimulus("halt reset");
    reset_n = 1'b1;
    apply_stimulus("halt warmup");
    retire_valid = 1'b1; retire_is_branch = 1'b1;
    apply_stimulus("br1");
    apply_stimulus("br2");
    retire_is_branch = 1'b0; retire_halt = 1'b1;
    apply_stimulus("hlt");
    chk("halted", 32'(is_halted_m), 32'd1);
    idle_inputs(); rd_sel = 3'd1;
    apply_stimulus("rd c1");
    chk("halt c1", rd_data_m, 32'd2);
    rd_sel = 3'd0;
    apply_stimulus("rd c0 h");
    chk("halt c0", rd_data_m, 32'd3);
    retire_valid = 1'b1; retire_is_branch = 1'b1; evt = 4'hF;
    for (int i = 0; i < 3; i++) apply_stimulus("post-halt");
    chk("post-halt num", 32'(num_inst_m), 32'd3);
    idle_inputs(); clear = 1'b1;
    apply_stimulus("halt clr");
    chk("halt clr num", 32'(num_inst_m), 32'd0);
    chk("halt clr still halted", 32'(is_halted_m), 32'd1);

    $display("[TB] mid-operation reset");
    idle_inputs(); reset_n = 1'b0;
    apply_stimulus("r6 reset");
    reset_n = 1'b1; retire_valid = 1'b1;
    for (int i = 0; i < 6; i++) apply_stimulus("r6 count");
    chk("r6 five", 32'(num_inst_m), 32'd5);
    reset_n = 1'b0;
    apply_stimulus("r6 reset2");
    chk("r6 reset num", 32'(num_inst_m), 32'd0);
    chk("r6 reset halted", 32'(is_halted_m), 32'd0);
    chk("r6 reset valid", 32'(output_valid_m), 32'd0);
    reset_n = 1'b1;
    apply_stimulus("r6 warm");
    apply_stimulus("r6 one");
    chk("r6 warmup again", 32'(num_inst_m), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
